// File: rtl/drum_pkg.sv
// Shared types and default sizes for the DRUM product accumulator.
package drum_pkg;

  localparam int DRUM_N     = 16;
  localparam int DRUM_M     = 16;
  localparam int DRUM_ACC_W = 40;
  localparam int DRUM_LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

endpackage

// File: rtl/drum_accum_if.sv
// Product-in / frame-sum-out handshake bundle for drum_accum.
interface drum_accum_if
  import drum_pkg::*;
#(
  parameter int N     = DRUM_N,
  parameter int M     = DRUM_M,
  parameter int ACC_W = DRUM_ACC_W,
  parameter int LEN_W = DRUM_LEN_W
);

  logic             in_valid;
  logic             in_ready;
  logic [N+M-1:0]   in_prod;
  logic [LEN_W-1:0] acc_len;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic             busy;

  modport master (
    output in_valid, in_prod, acc_len, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_prod, acc_len, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );

endinterface

// File: rtl/drum_sat_add.sv
// Accumulator adder; DRUM_ACC_SAT_EN selects saturating add
// with overflow flag, otherwise plain modular add.
module drum_sat_add
  import drum_pkg::*;
#(
  parameter int W = DRUM_ACC_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_ovf
);

`ifdef DRUM_ACC_SAT_EN
  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b};
  assign o_ovf  = w_full[W];
  assign o_sum  = w_full[W] ? '1 : w_full[W-1:0];
`else
  assign o_sum = i_a + i_b;
  assign o_ovf = 1'b0;
`endif

endmodule

// File: rtl/drum_accum.sv
// Frame accumulator for DRUM approximate products.
// Build option: DRUM_ACC_SAT_EN (saturating sum + out_ovf).
module drum_accum
  import drum_pkg::*;
#(
  parameter int N     = DRUM_N,
  parameter int M     = DRUM_M,
  parameter int ACC_W = DRUM_ACC_W,
  parameter int LEN_W = DRUM_LEN_W
) (
  input logic         clk,
  input logic         rst_n,
  drum_accum_if.slave bus
);

  state_t           r_state;
  state_t           w_next;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_sum;
  logic [ACC_W-1:0] w_add_a;
  logic [ACC_W-1:0] w_add_b;
  logic [ACC_W-1:0] w_add_s;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len_in;
  logic [LEN_W-1:0] w_len_cur;
  logic [LEN_W-1:0] w_cnt_nx;
  logic             r_ovf;
  logic             r_out_ovf;
  logic             w_add_ovf;
  logic             w_ovf_nx;
  logic             w_rdy;
  logic             w_beat;
  logic             w_first;
  logic             w_last;

  assign w_rdy   = rst_n && (r_state != HOLD);
  assign w_beat  = bus.in_valid && w_rdy;
  assign w_first = (r_state == IDLE);

  // length 0 on the first beat means a one-beat frame
  assign w_len_in  = (bus.acc_len == '0)
                   ? LEN_W'(1) : bus.acc_len;
  assign w_len_cur = w_first ? w_len_in : r_len;
  assign w_cnt_nx  = w_first ? LEN_W'(1)
                   : r_cnt + LEN_W'(1);
  assign w_last    = (w_cnt_nx == w_len_cur);

  assign w_add_a  = w_first ? '0 : r_acc;
  assign w_add_b  = ACC_W'(bus.in_prod);
  assign w_ovf_nx = (!w_first && r_ovf) || w_add_ovf;

  drum_sat_add #(.W(ACC_W)) u_add (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .o_sum (w_add_s),
    .o_ovf (w_add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_beat) w_next = w_last ? HOLD : ACCUM;
      end
      ACCUM: begin
        bus.busy = 1'b1;
        if (w_beat && w_last) w_next = HOLD;
      end
      HOLD: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_len     <= '0;
      r_ovf     <= 1'b0;
      r_sum     <= '0;
      r_out_ovf <= 1'b0;
    end else if (w_beat) begin
      r_acc <= w_add_s;
      r_cnt <= w_cnt_nx;
      r_ovf <= w_ovf_nx;
      if (w_first) r_len <= w_len_in;
      if (w_last) begin
        r_sum     <= w_add_s;
        r_out_ovf <= w_ovf_nx;
      end
    end
  end

  assign bus.in_ready = w_rdy;
  assign bus.out_sum  = r_sum;
  assign bus.out_ovf  = r_out_ovf;

endmodule

// File: tb/tb_drum_accum.sv
// Bench for drum_accum: directed table, corner sequences
// and random frames against a frame-level sum model.
module tb_drum_accum;
  import drum_pkg::*;

  localparam int N  = 16;
  localparam int M  = 16;
  localparam int AW = 32;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  drum_accum_if #(
    .N(N), .M(M), .ACC_W(AW), .LEN_W(LW)
  ) bus ();

  drum_accum #(
    .N(N), .M(M), .ACC_W(AW), .LEN_W(LW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  logic [31:0] beats[$];
  logic [31:0] f_sum;
  logic        f_ovf;

  // expected result from the whole frame's arithmetic total
  task automatic model(output logic [31:0] s,
                       output logic o);
    longint unsigned tot;
    tot = 0;
    foreach (beats[i]) tot += beats[i];
`ifdef DRUM_ACC_SAT_EN
    if (tot > 64'hFFFF_FFFF) begin
      s = '1;
      o = 1'b1;
    end else begin
      s = tot[31:0];
      o = 1'b0;
    end
`else
    s = tot[31:0];
    o = 1'b0;
`endif
  endtask

  task automatic run_frame(input int lenf,
                           input int gapmax,
                           input int hold,
                           input int junk);
    int g;
    for (int i = 0; i < beats.size(); i++) begin
      g = (i == 0) ? 0 : $urandom_range(0, gapmax);
      repeat (g) begin
        @(negedge clk);
        chk("gap_valid", bus.out_valid, 0);
        bus.in_valid = 1'b0;
        bus.in_prod  = $urandom;
      end
      @(negedge clk);
      if (i > 0) begin
        chk("mid_valid", bus.out_valid, 0);
        chk("mid_busy", bus.busy, 1);
      end
      chk("beat_rdy", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_prod  = beats[i];
      if (i == 0)        bus.acc_len = LW'(lenf);
      else if (junk < 0) bus.acc_len = LW'($urandom);
      else               bus.acc_len = LW'(junk);
    end
    @(negedge clk);
    chk("lat_valid", bus.out_valid, 1);
    f_sum = bus.out_sum;
    f_ovf = bus.out_ovf;
    bus.out_ready = (hold == 0);
    bus.in_valid  = (hold > 0);
    bus.in_prod   = $urandom;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_rdy", bus.in_ready, 0);
      chk("hold_sum", bus.out_sum, f_sum);
      chk("hold_ovf", bus.out_ovf, f_ovf);
      bus.out_ready = (k == hold - 1);
    end
    @(negedge clk);
    chk("post_valid", bus.out_valid, 0);
    chk("post_busy", bus.busy, 0);
    chk("post_rdy", bus.in_ready, 1);
    chk("post_sum", bus.out_sum, f_sum);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  typedef struct packed {
    int               lenf;
    int               nb;
    int               hold;
    logic [3:0][31:0] b;
    logic [31:0]      es;
    logic             eo;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [31:0] es;
    logic        eo;
    int          lenf;
    int          nb;

    tbl[0] = '{lenf: 4, nb: 4, hold: 0,
               b: {32'd40, 32'd30, 32'd20, 32'd10},
               es: 32'd100, eo: 1'b0};
    tbl[1] = '{lenf: 0, nb: 1, hold: 1,
               b: {96'd0, 32'hFFFF_FFFF},
               es: 32'hFFFF_FFFF, eo: 1'b0};
`ifdef DRUM_ACC_SAT_EN
    tbl[2] = '{lenf: 2, nb: 2, hold: 0,
               b: {64'd0, 32'd2, 32'hFFFF_FFFF},
               es: 32'hFFFF_FFFF, eo: 1'b1};
`else
    tbl[2] = '{lenf: 2, nb: 2, hold: 0,
               b: {64'd0, 32'd2, 32'hFFFF_FFFF},
               es: 32'd1, eo: 1'b0};
`endif
    tbl[3] = '{lenf: 3, nb: 3, hold: 5,
               b: {32'd0, 32'd9, 32'd8, 32'd7},
               es: 32'd24, eo: 1'b0};
    tbl[4] = '{lenf: 1, nb: 1, hold: 2,
               b: {96'd0, 32'd123},
               es: 32'd123, eo: 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.acc_len   = '0;
    bus.out_ready = 1'b0;

    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rdy", bus.in_ready, 0);
    chk("rst_sum", bus.out_sum, 0);
    chk("rst_ovf", bus.out_ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 5; t++) begin
      beats.delete();
      for (int j = 0; j < tbl[t].nb; j++)
        beats.push_back(tbl[t].b[j]);
      run_frame(tbl[t].lenf, 0, tbl[t].hold, -1);
      chk($sformatf("tbl%0d_sum", t), f_sum, tbl[t].es);
      chk($sformatf("tbl%0d_ovf", t), f_ovf, tbl[t].eo);
    end

    // mid-frame acc_len change plus input gaps
    beats = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_frame(4, 2, 1, 1);
    chk("lenchg_sum", f_sum, 32'd10);
    chk("lenchg_ovf", f_ovf, 0);

    // reset in the middle of a frame discards it
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_prod  = 32'd100;
    bus.acc_len  = LW'(4);
    @(negedge clk);
    bus.in_prod  = 32'd200;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_rdy", bus.in_ready, 0);
    chk("mrst_sum", bus.out_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    beats = '{32'd5, 32'd6};
    run_frame(2, 0, 0, -1);
    chk("rst_new_sum", f_sum, 32'd11);
    chk("rst_new_ovf", f_ovf, 0);

    for (int r = 0; r < 40; r++) begin
      lenf = $urandom_range(0, 12);
      nb   = (lenf == 0) ? 1 : lenf;
      beats.delete();
      for (int j = 0; j < nb; j++) begin
        if ($urandom_range(0, 3) == 0)
          beats.push_back($urandom);
        else
          beats.push_back(32'($urandom_range(0, 1000)));
      end
      model(es, eo);
      run_frame(lenf, 2, $urandom_range(0, 3), -1);
      chk($sformatf("rnd%0d_sum", r), f_sum, es);
      chk($sformatf("rnd%0d_ovf", r), f_ovf, eo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/drum_accum.md
DRUM_ACCUM -- requirements
Module: drum_accum

Interface
REQ-001 SHALL have parameter N, default 16, width of multiplicand a of the upstream DRUM multiplier.
REQ-002 SHALL have parameter M, default 16, width of multiplier b of the upstream DRUM multiplier.
REQ-003 SHALL have parameter ACC_W, default 40, accumulator width; ACC_W >= N+M.
REQ-004 SHALL have parameter LEN_W, default 8, frame-length field width.
REQ-005 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, product beat valid.
REQ-008 SHALL have port in_ready, output, 1, block accepts a beat.
REQ-009 SHALL have port in_prod, input, N+M, unsigned approximate product r from the DRUM multiplier.
REQ-010 SHALL have port acc_len, input, LEN_W, products per frame; sampled on first beat only.
REQ-011 SHALL have port out_valid, output, 1, frame sum valid.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts sum.
REQ-013 SHALL have port out_sum, output, ACC_W, frame sum.
REQ-014 SHALL have port out_ovf, output, 1, frame overflow flag.
REQ-015 SHALL have port busy, output, 1, high in ACCUM or HOLD.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM, HOLD.
REQ-017 Beat transfer SHALL occur exactly on a rising edge with in_valid && in_ready.
REQ-018 in_ready SHALL be 1 in IDLE and ACCUM, 0 in HOLD; in_ready SHALL NOT depend on in_valid.
REQ-019 IDLE + beat: latch acc_len (0 treated as 1), acc = zero-extended in_prod, cnt = 1; go to HOLD if length is 1, else ACCUM.
REQ-020 ACCUM + beat: acc += zero-extended in_prod, cnt += 1; go to HOLD when cnt reaches latched length; no beat means state and acc hold.
REQ-021 out_valid SHALL rise the cycle after the last beat is accepted (latency 1 cycle), with out_sum including that beat.
REQ-022 In HOLD, out_sum/out_ovf SHALL be stable until out_valid && out_ready; then go to IDLE next cycle, no same-cycle new-frame beat.
REQ-023 out_valid SHALL be 0 outside HOLD; out_sum SHALL retain the last frame value outside HOLD.
REQ-024 Changes of acc_len mid-frame SHALL have no effect.
REQ-025 Max frame length 2^LEN_W-1 beats; cnt SHALL NOT wrap.

Reset
REQ-026 On rst_n low, immediately: state IDLE, acc 0, cnt 0, out_sum 0, out_ovf 0, out_valid 0, busy 0, in_ready 0 while asserted.
REQ-027 Reset mid-frame or in HOLD SHALL discard the partial/pending frame; first beat after deassertion starts a new frame.

Configuration
REQ-028 Macro DRUM_ACC_SAT_EN SHALL be the only compile option.
REQ-029 With DRUM_ACC_SAT_EN: addition saturates at 2^ACC_W-1; out_ovf set sticky for the frame on any saturating add.
REQ-030 Without DRUM_ACC_SAT_EN: addition wraps mod 2^ACC_W; out_ovf constant 0.

Structure
REQ-031 Package drum_pkg SHALL hold the state enum (IDLE/ACCUM/HOLD) and default N, M, ACC_W, LEN_W constants.
REQ-032 One sub-module drum_sat_add (ACC_W adder with optional saturation and overflow output) SHALL be instantiated for the accumulate path.

Verification
REQ-033 acc_len=4, beats 10,20,30,40 back-to-back, out_ready=1 -> out_valid 1 cycle after 4th beat, out_sum=100, out_ovf=0.
REQ-034 acc_len=0, single beat 0xFFFF_FFFF -> treated as length 1, out_sum=0xFFFF_FFFF next cycle.
REQ-035 acc_len=3, out_ready=0 for 5 cycles after out_valid -> out_sum stable, in_ready=0, in_valid beats not accepted; release -> IDLE next cycle.
REQ-036 ACC_W=32, acc_len=2, beats 0xFFFF_FFFF and 2 -> with DRUM_ACC_SAT_EN out_sum=0xFFFF_FFFF, out_ovf=1; without, out_sum=1, out_ovf=0.
REQ-037 rst_n low after 2 of 4 beats, then new frame acc_len=2 beats 5,6 -> out_sum=11, no residue.
REQ-038 acc_len changed 4->1 after first beat, with in_valid gaps -> frame still completes after 4 beats with correct sum.
